// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port wins by default, fetch wins after MAX_WAIT denied cycles.
// Optional perf counters (conflict_cnt, starve_cnt) when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_type,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_we,
  output logic [2:0]    mem_type,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]   conflict_cnt,
  output logic [31:0]   starve_cnt,
`endif
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

  typedef struct packed {
    logic          we;
    logic [2:0]    typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  owner_t   rd_owner, rd_owner_nxt;
  logic [3:0] wait_cnt;
  logic     starve;
  mem_req_t mreq;

  assign starve = (wait_cnt >= 4'(MAX_WAIT));

  // Grants are qualified by rst so outputs read zero while reset is held.
  assign d_gnt  = rst & d_req & ~(if_req & starve);
  assign if_gnt = rst & if_req & ~d_gnt;

  always_comb begin
    mreq = '0;
    if (d_gnt) begin
      mreq.we    = d_we;
      mreq.typ   = d_type;
      mreq.addr  = d_addr;
      mreq.wdata = d_wdata;
    end else if (if_gnt) begin
      mreq.typ   = 3'b010;
      mreq.addr  = if_addr;
    end
  end

  assign mem_we    = mreq.we;
  assign mem_type  = mreq.typ;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (if_gnt)              rd_owner_nxt = OWN_FETCH;
    else if (d_gnt && !d_we) rd_owner_nxt = OWN_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      rd_owner <= rd_owner_nxt;
      if (if_req && !if_gnt) wait_cnt <= (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
      else                   wait_cnt <= '0;
    end
  end

  assign if_rvalid = (rd_owner == OWN_FETCH);
  assign d_rvalid  = (rd_owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
  // A forced grant is one the data port would otherwise have taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
      starve_cnt   <= '0;
    end else begin
      if (if_req && d_req)            conflict_cnt <= conflict_cnt + 32'd1;
      if (if_gnt && d_req && starve)  starve_cnt   <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read word memory model.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]    d_type, mem_type;
  logic [AW-1:0] d_addr, mem_addr;
  logic [DW-1:0] d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic          mem_we;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt, starve_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mem [0:255];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_PERF_EN
    .conflict_cnt(conflict_cnt), .starve_cnt(starve_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem_rdata = '0;

    // 1: reset with random inputs
    rst = 1'b0;
    if_req = 1'b1; if_addr = $urandom; d_req = 1'b1; d_we = 1'b1;
    d_type = 3'($urandom); d_addr = $urandom; d_wdata = $urandom;
    #1;
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    step(); step();
    #1;
    chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    step();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("t1_if_gnt", 64'(if_gnt), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h40);
    chk("t1_mem_type", 64'(mem_type), 64'd2);
    step();
    if_req = 1'b0;
    #1;
    chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1_if_rdata", 64'(if_rdata), 64'hA000_0010);
    chk("t1_d_rvalid", 64'(d_rvalid), 64'd0);

    // 2: store then load at 0x100
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_type = 3'b010;
    #1;
    chk("t2_st_gnt", 64'(d_gnt), 64'd1);
    chk("t2_mem_we", 64'(mem_we), 64'd1);
    chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    step();
    d_we = 1'b0;
    #1;
    chk("t2_st_no_rvalid", 64'(d_rvalid), 64'd0);
    chk("t2_ld_mem_we", 64'(mem_we), 64'd0);
    chk("t2_ld_gnt", 64'(d_gnt), 64'd1);
    step();
    d_req = 1'b0;
    #1;
    chk("t2_ld_rvalid", 64'(d_rvalid), 64'd1);
    chk("t2_ld_rdata", 64'(d_rdata), 64'hDEAD_BEEF);
    chk("t2_if_rvalid", 64'(if_rvalid), 64'd0);

    // 3: sustained conflict; fetch wins every 5th cycle
    step();
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("t3_d_gnt_c%0d", c), 64'(d_gnt), 64'(c % 5 != 0));
      chk($sformatf("t3_if_gnt_c%0d", c), 64'(if_gnt), 64'(c % 5 == 0));
      chk($sformatf("t3_if_rvalid_c%0d", c), 64'(if_rvalid), 64'(c == 6));
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    #1;
`ifdef MEM_ARB_PERF_EN
    chk("t6_conflict_cnt", 64'(conflict_cnt), 64'd10);
    chk("t6_starve_cnt", 64'(starve_cnt), 64'd2);
`endif
    chk("t3_tail_if_rvalid", 64'(if_rvalid), 64'd1);

    // 4: fetch then load, consecutive returns without cross-routing
    step();
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("t4_if_gnt", 64'(if_gnt), 64'd1);
    step();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    #1;
    chk("t4_d_gnt", 64'(d_gnt), 64'd1);
    chk("t4_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t4_if_rdata", 64'(if_rdata), 64'hA000_0000);
    chk("t4_d_rvalid0", 64'(d_rvalid), 64'd0);
    chk("t4_d_rdata0", 64'(d_rdata), 64'd0);
    step();
    d_req = 1'b0;
    #1;
    chk("t4_d_rvalid", 64'(d_rvalid), 64'd1);
    chk("t4_d_rdata", 64'(d_rdata), 64'hA000_0002);
    chk("t4_if_rvalid1", 64'(if_rvalid), 64'd0);
    chk("t4_if_rdata1", 64'(if_rdata), 64'd0);

    // 5: reset in the cycle after a fetch grant
    step();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("t5_if_gnt", 64'(if_gnt), 64'd1);
    step();
    if_req = 1'b0; rst = 1'b0;
    #1;
    chk("t5_rvalid_in_rst", 64'(if_rvalid), 64'd0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rvalid_release", 64'(if_rvalid), 64'd0);
    step();
    #1;
    chk("t5_rvalid_after", 64'(if_rvalid), 64'd0);
    chk("t5_d_rvalid_after", 64'(d_rvalid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
